present_enc_core: RTL and testbench
===================================

Name: present_enc_core

Overview:
- PRESENT-80 encryption datapath and round controller that sits directly downstream of the round-key scheduler `key`.
- It accepts a plaintext/key pair over a valid/ready handshake and drives `key` through its load and step controls.
- Each round it consumes `key.roundk` to run addRoundKey, sLayer and pLayer, and it returns the ciphertext over a valid/ready handshake.
- One block is processed at a time; the block is iterative, one round per cycle.

Parameters:
- NUM_ROUNDS, 31, number of full rounds. Legal range 1..31; production value is 31. The final whitening key is K(NUM_ROUNDS+1).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low. Asserting it clears every register regardless of state.
- in_valid  in  1  plaintext/key present.
- in_ready  out  1  block can accept; high only in IDLE.
- in_data  in  64  plaintext.
- in_key  in  80  cipher key.
- out_valid  out  1  ciphertext present.
- out_ready  in  1  consumer accepts.
- out_data  out  64  ciphertext, held stable while out_valid=1.
- ks_load  out  1  to `key.rst`; synchronous load strobe for the scheduler.
- ks_en  out  1  to `key.enable`.
- ks_round  out  5  to `key.rounds`.
- ks_key  out  80  to `key.key`; registered copy of in_key.
- ks_roundk  in  64  from `key.roundk`.

Behaviour:
- Reset values:
  - state register = 0, out_data = 0, ks_key = 0, round counter rnd = 0.
  - out_valid = 0, ks_load = 0, ks_en = 0, FSM = IDLE, in_ready = 1 after reset release.
- FSM states: IDLE, LOAD, ROUND, FINAL, DONE.
- IDLE:
  - in_ready = 1.
  - Accept on the edge with in_valid & in_ready: state <= in_data, ks_key <= in_key, rnd <= 0, go to LOAD.
- LOAD (1 cycle):
  - ks_load = 1 (decoded from state, combinational), ks_en = 0.
  - At the next edge the scheduler loads ks_key and presents K1 on ks_roundk. Go to ROUND.
- ROUND:
  - ks_en = 1, ks_round = rnd.
  - Each edge: state <= pLayer(sLayer(state ^ ks_roundk)), rnd <= rnd+1.
  - In the same edge the scheduler advances to K(rnd+2).
  - When rnd = NUM_ROUNDS-1, go to FINAL.
  - ks_round must equal rnd exactly while ks_en = 1. The scheduler adds 1 internally to form the round constant.
- FINAL (1 cycle):
  - ks_en = 0.
  - out_data <= state ^ ks_roundk (K(NUM_ROUNDS+1)), out_valid <= 1, go to DONE.
- DONE:
  - out_valid = 1 and out_data held.
  - On out_ready = 1: out_valid <= 0, go to IDLE.
  - in_ready stays 0 in DONE, so a new block is accepted no earlier than the cycle after the output handshake.
- ks_load, ks_en and ks_round are zero in every state not listed above. ks_round = 0 whenever ks_en = 0.
- sLayer: 16 parallel 4-bit S-boxes, nibble i = bits [4i+3:4i]. Table, input 0..F maps to C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- pLayer: bit i moves to position (16*i) mod 63 for i = 0..62; bit 63 stays at 63.
- Latency: out_valid rises NUM_ROUNDS+2 clock edges after the accept edge (33 for the default). Throughput is one block per NUM_ROUNDS+4 cycles with out_ready tied high.
- in_data/in_key changes after acceptance have no effect.
- out_ready while out_valid = 0 is ignored.
- Reset asserted mid-round: asynchronous clear to the reset values. No partial output is emitted. The scheduler is reloaded on the next accept.

Test Plan:
- pt=0000000000000000, key=0 -> out_data=5579C1387B228445; out_valid rises 33 edges after accept.
- pt=0, key=FFFFFFFFFFFFFFFFFFFF -> E72C46C0F5945049. Also check ks_round steps 0..30 with ks_en high for exactly 31 cycles and ks_load high for exactly 1 cycle.
- pt=FFFFFFFFFFFFFFFF, key=0 -> A112FFC72F68417B. Hold out_ready=0 for 10 cycles: out_valid and out_data stable, in_ready=0, and in_valid pulses are ignored.
- pt=FFFFFFFFFFFFFFFF, key=FF..F -> 3333DCD3213210D2. Run back-to-back with the previous vector and out_ready tied 1: second accept occurs the cycle after the first output handshake.
- Assert rst at round 12, release, then send pt=0/key=0 -> all outputs at reset values during reset; the next result is still 5579C1387B228445.
- Toggle in_data/in_key randomly after acceptance of pt=0/key=0 -> result unchanged, 5579C1387B228445.

Source files
------------

// File: rtl/present_enc_core.sv
// PRESENT-80 iterative encryption datapath and round controller.
// Drives an external round-key scheduler and runs one full round per clock.
module present_enc_core #(
  parameter int unsigned NUM_ROUNDS = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [79:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        ks_load,
  output logic        ks_en,
  output logic [4:0]  ks_round,
  output logic [79:0] ks_key,
  input  logic [63:0] ks_roundk
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRound,
    StFinal,
    StDone
  } fsm_e;

  localparam logic [4:0] LastRnd = 5'(NUM_ROUNDS - 1);

  fsm_e        fsm_q, fsm_d;
  logic [63:0] state_q, state_d;
  logic [63:0] out_data_q, out_data_d;
  logic [79:0] key_q, key_d;
  logic [4:0]  rnd_q, rnd_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] round_out;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) begin
      y[4*n +: 4] = sbox(x[4*n +: 4]);
    end
    return y;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    logic [5:0]  idx;
    y = '0;
    for (int b = 0; b < 63; b++) begin
      idx    = 6'((16 * b) % 63);
      y[idx] = x[b];
    end
    y[63] = x[63];
    return y;
  endfunction

  assign round_out = p_layer(s_layer(state_q ^ ks_roundk));

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    out_data_d  = out_data_q;
    key_d       = key_q;
    rnd_d       = rnd_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
    ks_load     = 1'b0;
    ks_en       = 1'b0;
    ks_round    = 5'd0;
    unique case (fsm_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = in_data;
          key_d   = in_key;
          rnd_d   = 5'd0;
          fsm_d   = StLoad;
        end
      end
      StLoad: begin
        ks_load = 1'b1;
        fsm_d   = StRound;
      end
      StRound: begin
        // Scheduler steps in the same edge, so K(rnd+2) is ready next cycle.
        ks_en    = 1'b1;
        ks_round = rnd_q;
        state_d  = round_out;
        rnd_d    = rnd_q + 5'd1;
        if (rnd_q == LastRnd) begin
          fsm_d = StFinal;
        end
      end
      StFinal: begin
        out_data_d  = state_q ^ ks_roundk;
        out_valid_d = 1'b1;
        fsm_d       = StDone;
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = StIdle;
        end
      end
      default: begin
        fsm_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q       <= StIdle;
      state_q     <= '0;
      out_data_q  <= '0;
      key_q       <= '0;
      rnd_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      key_q       <= key_d;
      rnd_q       <= rnd_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign ks_key    = key_q;

endmodule

// File: tb/tb_present_enc_core.sv
// Bench for present_enc_core: models the external key scheduler and checks
// ciphertexts, timing and handshakes against a behavioural PRESENT-80 model.
module tb_present_enc_core;

  localparam int NR = 31;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [79:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        ks_load;
  logic        ks_en;
  logic [4:0]  ks_round;
  logic [79:0] ks_key;
  logic [63:0] ks_roundk;

  int total = 0;
  int bad   = 0;

  logic [3:0] sbox_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                              4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  present_enc_core #(.NUM_ROUNDS(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ks_load   (ks_load),
    .ks_en     (ks_en),
    .ks_round  (ks_round),
    .ks_key    (ks_key),
    .ks_roundk (ks_roundk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [79:0] key_next(input logic [79:0] k, input int r);
    logic [79:0] n;
    logic [4:0]  rc;
    rc = 5'(r);
    n = {k[18:0], k[79:19]};
    n[79:76] = sbox_t[n[79:76]];
    n[19:15] = n[19:15] ^ rc;
    return n;
  endfunction

  function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [79:0] key,
                                         input int nr);
    logic [63:0] s, t;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int r = 1; r <= nr; r++) begin
      s = s ^ k[79:16];
      for (int j = 0; j < 16; j++) s[4*j +: 4] = sbox_t[s[4*j +: 4]];
      t = '0;
      for (int b = 0; b < 64; b++) t[(b == 63) ? 63 : (16 * b) % 63] = s[b];
      s = t;
      k = key_next(k, r);
    end
    return s ^ k[79:16];
  endfunction

  // Round-key scheduler sitting upstream of the DUT.
  logic [79:0] sched_q;
  always @(posedge clk or negedge rst) begin
    if (!rst) sched_q <= '0;
    else if (ks_load) sched_q <= ks_key;
    else if (ks_en) sched_q <= key_next(sched_q, int'(ks_round) + 1);
  end
  assign ks_roundk = sched_q[79:16];

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [63:0] pt, input logic [79:0] k);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = pt;
    in_key   = k;
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 160'(in_ready), 160'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Runs from just after the accept edge until out_valid is seen.
  task automatic collect(input logic [63:0] exp, input bit scramble);
    int m, en_cnt, load_cnt, rerr;
    m = 0; en_cnt = 0; load_cnt = 0; rerr = 0;
    while (m < 100) begin
      @(negedge clk);
      m++;
      if (scramble) begin
        in_data = {$urandom, $urandom};
        in_key  = {16'($urandom), $urandom, $urandom};
      end
      if (out_valid) break;
      if (ks_load) load_cnt++;
      if (ks_en) begin
        if (int'(ks_round) != en_cnt) rerr++;
        en_cnt++;
      end else if (ks_round != 5'd0) begin
        rerr++;
      end
    end
    check("out_valid_rise", 160'(out_valid), 160'(1));
    check("latency", 160'(m - 1), 160'(NR + 2));
    check("ciphertext", 160'(out_data), 160'(exp));
    check("ks_en_cycles", 160'(en_cnt), 160'(NR));
    check("ks_load_cycles", 160'(load_cnt), 160'(1));
    check("ks_round_seq_errs", 160'(rerr), 160'(0));
  endtask

  task automatic hold_and_drain(input logic [63:0] exp, input int h);
    for (int i = 0; i < h; i++) begin
      in_valid = 1'($urandom);
      in_data  = {$urandom, $urandom};
      in_key   = {16'($urandom), $urandom, $urandom};
      @(negedge clk);
      check("hold", {out_valid, in_ready, out_data}, {1'b1, 1'b0, exp});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("drained", {out_valid, in_ready}, {1'b1 ^ 1'b1, 1'b1});
  endtask

  logic [63:0] pt_r;
  logic [79:0] key_r;
  logic [63:0] exp_r;

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_key    = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", {out_valid, out_data, ks_key, ks_load, ks_en, ks_round}, '0);
    rst = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 160'(in_ready), 160'(1));

    // Reference model anchored to published vectors.
    check("ref_0_0", 160'(ref_enc(64'h0, 80'h0, NR)), 160'(64'h5579C1387B228445));

    accept(64'h0, 80'h0);
    collect(64'h5579C1387B228445, 1'b0);
    hold_and_drain(64'h5579C1387B228445, 0);

    accept(64'h0, {80{1'b1}});
    collect(64'hE72C46C0F5945049, 1'b0);
    hold_and_drain(64'hE72C46C0F5945049, 0);

    accept({64{1'b1}}, 80'h0);
    collect(64'hA112FFC72F68417B, 1'b0);
    hold_and_drain(64'hA112FFC72F68417B, 10);

    // Back-to-back: second block waits while the first completes.
    out_ready = 1'b1;
    accept({64{1'b1}}, 80'h0);
    in_valid = 1'b1;
    in_data  = {64{1'b1}};
    in_key   = {80{1'b1}};
    collect(64'hA112FFC72F68417B, 1'b0);
    @(negedge clk);
    check("b2b_idle", {out_valid, in_ready}, {1'b0, 1'b1});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    collect(64'h3333DCD3213210D2, 1'b0);
    @(negedge clk);
    check("b2b_done", {out_valid, in_ready}, {1'b0, 1'b1});
    out_ready = 1'b0;

    // Reset in the middle of round 12.
    accept({$urandom, $urandom}, {16'($urandom), $urandom, $urandom});
    for (int i = 0; i < 60; i++) begin
      if (ks_en && ks_round == 5'd12) break;
      @(negedge clk);
    end
    check("reached_round12", {ks_en, ks_round}, {1'b1, 5'd12});
    #2;
    rst = 1'b0;
    #1;
    check("midrst_outs", {out_valid, out_data, ks_key, ks_load, ks_en, ks_round}, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_release", {out_valid, in_ready}, {1'b0, 1'b1});
    accept(64'h0, 80'h0);
    collect(64'h5579C1387B228445, 1'b0);
    hold_and_drain(64'h5579C1387B228445, 1);

    // Inputs scrambled after acceptance must not matter.
    accept(64'h0, 80'h0);
    collect(64'h5579C1387B228445, 1'b1);
    hold_and_drain(64'h5579C1387B228445, 2);

    for (int v = 0; v < 6; v++) begin
      pt_r  = {$urandom, $urandom};
      key_r = {16'($urandom), $urandom, $urandom};
      exp_r = ref_enc(pt_r, key_r, NR);
      accept(pt_r, key_r);
      collect(exp_r, 1'b0);
      hold_and_drain(exp_r, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
